// File: rtl/mpc_sram_ctrl_if.sv
// Client-side channels of mpc_sram_ctrl: request (valid/ready) and read response (valid/ready).
// Handshake: a beat transfers on a clock edge where valid & ready are both 1. The sender holds
// valid and payload stable until that edge. ready may depend combinationally on the other side.
interface mpc_sram_ctrl_if #(
  parameter int ADDR_SIZE = 2,
  parameter int DATA_SIZE = 2
) ();
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [DATA_SIZE-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_SIZE-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mpc_sram_ctrl.sv
// Initiator-side controller for a 1RW SRAM: post-reset init sweep, request channel with
// credit-based flow control, and an in-order read-response FIFO that absorbs client backpressure.
module mpc_sram_ctrl #(
  parameter int                  ADDR_SIZE  = 2,
  parameter int                  DATA_SIZE  = 2,
  parameter int                  DEPTH      = 2**ADDR_SIZE,
  parameter bit                  INIT_EN    = 1'b1,
  parameter logic [DATA_SIZE-1:0] INIT_VALUE = '0,
  parameter int                  RSP_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mpc_sram_ctrl_if.slave       bus,
  output logic                 init_done,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic [ADDR_SIZE-1:0] sram_addr,
  output logic [DATA_SIZE-1:0] sram_wdata,
  input  logic [DATA_SIZE-1:0] sram_rdata,
  output logic                 dbg_state
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t ST_RESET = INIT_EN ? ST_INIT : ST_RUN;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] init_cnt_q;
  logic                 init_done_q;
  logic                 inflight_q;
  logic [DATA_SIZE-1:0] buf_q [RSP_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  logic                 init_last;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [CNT_W:0]       occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign init_last = (init_cnt_q == ADDR_SIZE'(DEPTH - 1));
  assign accept    = bus.req_valid & bus.req_ready;
  assign push      = inflight_q;
  assign pop       = bus.rsp_valid & bus.rsp_ready;

  // Slots already committed after this cycle: buffered + in flight, minus the one leaving now.
  // This makes req_ready combinationally dependent on rsp_ready, by design.
  assign occupancy     = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign bus.req_ready = init_done_q & (occupancy < (CNT_W+1)'(RSP_DEPTH));
  assign bus.rsp_valid = (count_q != '0);
  assign bus.rsp_rdata = buf_q[rd_ptr_q];
  assign init_done     = init_done_q;
  assign dbg_state     = state_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RESET;
    else     state_q <= state_d;
  end

  // Next-state logic; RUN is terminal until reset
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && init_last) state_d = ST_RUN;
  end

  // Output logic: the SRAM pins are forced idle while reset is held
  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          sram_cs    = 1'b1;
          sram_we    = 1'b1;
          sram_addr  = init_cnt_q;
          sram_wdata = INIT_VALUE;
        end
        default: begin
          sram_cs = accept;
          if (accept) begin
            sram_we    = bus.req_we;
            sram_addr  = bus.req_addr;
            sram_wdata = bus.req_wdata;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + ADDR_SIZE'(1);
      init_done_q <= (state_d == ST_RUN);
      inflight_q  <= accept & ~bus.req_we;
    end
  end

  // Response storage carries no reset; validity comes from count_q
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= sram_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count_q == CNT_W'(RSP_DEPTH)));

endmodule

// File: tb/tb_mpc_sram_ctrl.sv
// Self-checking bench for mpc_sram_ctrl: one instance with the init sweep, one without.
module tb_mpc_sram_ctrl;
  localparam int              AW = 2;
  localparam int              DW = 2;
  localparam int              RD = 2;
  localparam logic [DW-1:0]   IV = 2'b10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  mpc_sram_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus  ();
  mpc_sram_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus1 ();

  logic          init_done, sram_cs, sram_we, dbg_state;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic          init_done1, sram_cs1, sram_we1, dbg_state1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_wdata1, sram_rdata1;

  mpc_sram_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .INIT_EN(1'b1), .INIT_VALUE(IV), .RSP_DEPTH(RD)) dut (
    .clk(clk), .rst(rst), .bus(bus), .init_done(init_done), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .dbg_state(dbg_state));

  mpc_sram_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .INIT_EN(1'b0), .INIT_VALUE(IV), .RSP_DEPTH(RD)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1), .init_done(init_done1), .sram_cs(sram_cs1), .sram_we(sram_we1),
    .sram_addr(sram_addr1), .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata1), .dbg_state(dbg_state1));

  // SRAM models: registered read data, valid the cycle after a cs=1 read
  logic [DW-1:0] mem [4];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  // Second macro is read-only with contents addr ^ 2'b11
  always @(posedge clk) begin
    if (sram_cs1 && !sram_we1) sram_rdata1 <= sram_addr1 ^ 2'b11;
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [4];
  int            rsp_cnt = 0;
  int            acc_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) ref_mem[i] = IV;
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) check_eq("rsp_unexpected", 1, 0);
        else check_eq("rsp_data", bus.rsp_rdata, exp_q.pop_front());
        rsp_cnt++;
      end
      if (bus.req_valid && bus.req_ready) begin
        if (bus.req_we) ref_mem[bus.req_addr] = bus.req_wdata;
        else            exp_q.push_back(ref_mem[bus.req_addr]);
        acc_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      if (n > 3) bus.rsp_ready = 1'b1;
      tick();
      n++;
      @(negedge clk);
    end
    if (n >= 50) check_eq("send_timeout", n, 0);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    @(negedge clk);
    while (!init_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("init_wait", init_done, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base_acc, base_rsp;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    bus1.req_valid = 1'b0;
    bus1.req_we    = 1'b0;
    bus1.req_addr  = '0;
    bus1.req_wdata = '0;
    bus1.rsp_ready = 1'b1;

    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_sram_cs", sram_cs, 0);
    check_eq("rst_sram_we", sram_we, 0);
    check_eq("rst1_init_done", init_done1, 0);
    check_eq("rst1_req_ready", bus1.req_ready, 0);
    tick();

    // Init sweep: four writes of IV to addresses 0..3, then operational
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("sweep_cs", sram_cs, 1);
      check_eq("sweep_we", sram_we, 1);
      check_eq("sweep_addr", sram_addr, i);
      check_eq("sweep_wdata", sram_wdata, IV);
      check_eq("sweep_done_low", init_done, 0);
    end
    @(negedge clk);
    check_eq("sweep_done", init_done, 1);
    check_eq("sweep_cs_idle", sram_cs, 0);
    check_eq("run_ready", bus.req_ready, 1);
    check_eq("run_state", dbg_state, 1);
    tick();

    for (int i = 0; i < 4; i++) send(1'b0, AW'(i), '0);
    repeat (4) tick();
    check_eq("init_reads_cnt", rsp_cnt, 4);
    check_eq("init_reads_q", exp_q.size(), 0);

    // Write then read back-to-back, 2-cycle read latency
    send(1'b1, 2'd1, 2'b01);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 2'd1;
    @(negedge clk);
    check_eq("raw_accept", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq("raw_lat1", bus.rsp_valid, 0);
    tick();
    @(negedge clk);
    check_eq("raw_lat2", bus.rsp_valid, 1);
    check_eq("raw_data", bus.rsp_rdata, 2'b01);
    tick();

    // Throughput: 8 back-to-back reads, responses on consecutive cycles
    send(1'b1, 2'd0, 2'd3);
    send(1'b1, 2'd1, 2'd1);
    send(1'b1, 2'd2, 2'd0);
    send(1'b1, 2'd3, 2'd2);
    tick();
    base_rsp = rsp_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = AW'(i % 4);
      @(negedge clk);
      check_eq("tp_ready", bus.req_ready, 1);
      if (i >= 2) check_eq("tp_rsp_valid", bus.rsp_valid, 1);
      tick();
    end
    bus.req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("tp_tail_valid", bus.rsp_valid, 1);
      tick();
    end
    @(negedge clk);
    check_eq("tp_end_valid", bus.rsp_valid, 0);
    check_eq("tp_rsp_cnt", rsp_cnt - base_rsp, 8);
    tick();

    // Backpressure: only RSP_DEPTH reads accepted, head stable, then drain
    bus.rsp_ready = 1'b0;
    base_acc = acc_cnt;
    base_rsp = rsp_cnt;
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = AW'(acc_cnt - base_acc);
      @(negedge clk);
      tick();
    end
    check_eq("bp_accepts", acc_cnt - base_acc, RD);
    @(negedge clk);
    check_eq("bp_ready_low", bus.req_ready, 0);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_hold_valid", bus.rsp_valid, 1);
      check_eq("bp_hold_data", bus.rsp_rdata, 2'd3);
      tick();
    end
    bus.rsp_ready = 1'b1;
    repeat (4) tick();
    check_eq("bp_drain_cnt", rsp_cnt - base_rsp, RD);
    check_eq("bp_drain_q", exp_q.size(), 0);

    // Random mixed traffic with random backpressure
    for (int i = 0; i < 40; i++) begin
      bus.rsp_ready = 1'($urandom_range(0, 1));
      send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom_range(0, 3)));
    end
    bus.rsp_ready = 1'b1;
    repeat (5) tick();
    check_eq("rand_drain_q", exp_q.size(), 0);
    check_eq("rand_drain_valid", bus.rsp_valid, 0);

    // Reset mid-run discards buffered responses
    bus.rsp_ready = 1'b0;
    send(1'b0, 2'd2, '0);
    tick();
    @(negedge clk);
    check_eq("mr_buffered", bus.rsp_valid, 1);
    rst = 1'b1;
    #1;
    check_eq("mr_rsp_valid", bus.rsp_valid, 0);
    check_eq("mr_req_ready", bus.req_ready, 0);
    check_eq("mr_init_done", init_done, 0);
    check_eq("mr_sram_cs", sram_cs, 0);
    bus.rsp_ready = 1'b1;
    tick();
    rst = 1'b0;

    // Reset mid-sweep restarts from address 0
    @(negedge clk);
    check_eq("ms_addr0", sram_addr, 0);
    @(negedge clk);
    check_eq("ms_addr1", sram_addr, 1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("ms_rst_cs", sram_cs, 0);
    check_eq("ms_rst_we", sram_we, 0);
    check_eq("ms_rst_done", init_done, 0);
    check_eq("ms_rst_ready", bus.req_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("ms_restart_cs", sram_cs, 1);
    check_eq("ms_restart_addr", sram_addr, 0);
    wait_init();
    base_rsp = rsp_cnt;
    send(1'b0, 2'd2, '0);
    send(1'b0, 2'd1, '0);
    repeat (4) tick();
    check_eq("ms_reads_cnt", rsp_cnt - base_rsp, 2);
    check_eq("ms_reads_q", exp_q.size(), 0);

    // Instance without sweep: read of addr 0 accepted one cycle after release
    rst1 = 1'b0;
    bus1.req_valid = 1'b1;
    bus1.req_we    = 1'b0;
    bus1.req_addr  = 2'd0;
    tick();
    @(negedge clk);
    check_eq("ie0_init_done", init_done1, 1);
    check_eq("ie0_accept", bus1.req_ready, 1);
    check_eq("ie0_sram_cs", sram_cs1, 1);
    check_eq("ie0_state", dbg_state1, 1);
    tick();
    bus1.req_valid = 1'b0;
    @(negedge clk);
    check_eq("ie0_lat1", bus1.rsp_valid, 0);
    tick();
    @(negedge clk);
    check_eq("ie0_rsp_valid", bus1.rsp_valid, 1);
    check_eq("ie0_rsp_data", bus1.rsp_rdata, 2'b11);
    tick();
    @(negedge clk);
    check_eq("ie0_rsp_gone", bus1.rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
